// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the MIPS32 pipeline hazard controller.
// Forward selects match the core's three-input operand muxes.
package hazard_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_M     = 2'b01;
   localparam logic [1:0] FWD_W     = 2'b10;

   localparam logic [1:0] TUSE_BR   = 2'd0;
   localparam logic [1:0] TUSE_ALU  = 2'd1;
   localparam logic [1:0] TUSE_ST   = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LD   = 2'd2;

   typedef struct packed {
      logic [4:0] dst;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
   } stage_rec_t;

   localparam stage_rec_t BUBBLE = '0;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // A writer that claims its result is already available still needs E to produce it.
   function automatic logic [1:0] tnew_norm(input logic [4:0] dst, input logic [1:0] t);
      return ((dst != 5'd0) && (t == 2'd0)) ? TNEW_ALU : t;
   endfunction

   function automatic logic operand_stall(
      input logic [4:0] r,
      input logic [1:0] tuse,
      input logic [4:0] e_dst,
      input logic [1:0] e_tnew,
      input logic [4:0] m_dst,
      input logic [1:0] m_tnew
   );
      logic hit;
      hit = 1'b0;
      if ((r != 5'd0) && (tuse != TUSE_NONE)) begin
         if ((e_dst == r) && (e_tnew > tuse)) hit = 1'b1;
         if ((m_dst == r) && (m_tnew > tuse)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/fwd_pick.sv
// Forward-source selector for one operand: a ready M result beats any W result,
// register 0 never matches.
module fwd_pick
   import hazard_pkg::*;
(
   input  logic [4:0] reg_i,
   input  logic       m_en_i,
   input  logic [4:0] m_dst_i,
   input  logic [1:0] m_tnew_i,
   input  logic [4:0] w_dst_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_REG;
      if (reg_i != 5'd0) begin
         if (m_en_i && (m_dst_i == reg_i) && (m_tnew_i == 2'd0)) begin
            sel_o = FWD_M;
         end else if (w_dst_i == reg_i) begin
            sel_o = FWD_W;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W producers, raises the D stall and
// drives the forwarding mux selects for D, E and M consumers.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] d_dst,
   input  logic [1:0] d_tnew,
   output logic       stall,
   output logic [1:0] sel_rs_d,
   output logic [1:0] sel_rt_d,
   output logic [1:0] sel_rs_e,
   output logic [1:0] sel_rt_e,
   output logic [1:0] sel_rt_m
);

   stage_rec_t e_q, e_d;
   logic [4:0] m_dst_q, m_rt_q;
   logic [1:0] m_tnew_q;
   // W only needs its destination: nothing downstream consumes its latency.
   logic [4:0] w_dst_q;

   always_comb begin
      stall = operand_stall(d_rs, d_tuse_rs, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q)
            | operand_stall(d_rt, d_tuse_rt, e_q.dst, e_q.tnew, m_dst_q, m_tnew_q);
   end

   always_comb begin
      e_d = BUBBLE;
      if (!stall) begin
         e_d.dst  = d_dst;
         e_d.tnew = tnew_norm(d_dst, d_tnew);
         e_d.rs   = d_rs;
         e_d.rt   = d_rt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q      <= BUBBLE;
         m_dst_q  <= 5'd0;
         m_tnew_q <= 2'd0;
         m_rt_q   <= 5'd0;
         w_dst_q  <= 5'd0;
      end else begin
         e_q      <= e_d;
         m_dst_q  <= e_q.dst;
         m_tnew_q <= tnew_dec(e_q.tnew);
         m_rt_q   <= e_q.rt;
         w_dst_q  <= m_dst_q;
      end
   end

   fwd_pick u_pick_rs_d (
      .reg_i    (d_rs),
      .m_en_i   (1'b1),
      .m_dst_i  (m_dst_q),
      .m_tnew_i (m_tnew_q),
      .w_dst_i  (w_dst_q),
      .sel_o    (sel_rs_d)
   );

   fwd_pick u_pick_rt_d (
      .reg_i    (d_rt),
      .m_en_i   (1'b1),
      .m_dst_i  (m_dst_q),
      .m_tnew_i (m_tnew_q),
      .w_dst_i  (w_dst_q),
      .sel_o    (sel_rt_d)
   );

   fwd_pick u_pick_rs_e (
      .reg_i    (e_q.rs),
      .m_en_i   (1'b1),
      .m_dst_i  (m_dst_q),
      .m_tnew_i (m_tnew_q),
      .w_dst_i  (w_dst_q),
      .sel_o    (sel_rs_e)
   );

   fwd_pick u_pick_rt_e (
      .reg_i    (e_q.rt),
      .m_en_i   (1'b1),
      .m_dst_i  (m_dst_q),
      .m_tnew_i (m_tnew_q),
      .w_dst_i  (w_dst_q),
      .sel_o    (sel_rt_e)
   );

   // Store data in M can only come from W; the M-side match is disabled.
   fwd_pick u_pick_rt_m (
      .reg_i    (m_rt_q),
      .m_en_i   (1'b0),
      .m_dst_i  (5'd0),
      .m_tnew_i (2'd0),
      .w_dst_i  (w_dst_q),
      .sel_o    (sel_rt_m)
   );

endmodule
